ser2par_stream: RTL
===================

Name: ser2par_stream

Overview:
- Parametrised serial-to-parallel collector for the RepVGG accelerator datapath.
- Accepts a stream of LN words per beat under valid/ready handshake and assembles DP words into one parallel frame.
- Presents the frame on a valid/ready output held stable until consumed.
- A fill buffer plus an output register let the next frame load while the previous one waits downstream.

Parameters:
- DW, 32, word width in bits.
- DP, 56, words per output frame; must be a multiple of LN.
- LN, 1, words per input beat (lanes); legal values 1, 2, 4, 8.
- Derived localparams: NB = DP/LN (beats per frame); PW = max(1, clog2(NB)) (beat pointer width).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear; discards all buffered data.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DW*LN  lane j carries in_data[j*DW +: DW].
- in_last  in  1  early frame close (present only with SER2PAR_FLUSH_EN).
- out_valid  out  1  parallel frame valid.
- out_ready  in  1  downstream accepts the frame when out_valid & out_ready.
- out_data  out  DW*DP  parallel frame.
- out_cnt  out  clog2(DP+1)  number of valid words in the frame.

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk. On reset:
  - beat pointer = 0, fill_full = 0, fill buffer = 0, output register = 0.
  - out_valid = 0, out_cnt = 0, in_ready = 1.
- Accept: in_ready = !fill_full, a registered value only; there is no combinational path from out_ready to in_ready.
- Ordering: the k-th word of a frame (k = beat*LN + lane, 0-based) lands at out_data[k*DW +: DW].
- Each accepted beat writes LN words at slot ptr*LN and increments ptr.
- Final beat (ptr == NB-1): ptr wraps to 0 and the frame is complete.
  - If the output register is free this cycle (!out_valid | out_ready), the complete frame, including the final beat's data, loads into the output register on that same edge: out_valid=1, out_cnt=DP. Latency is 0 cycles after the final accept edge.
  - Otherwise fill_full=1 and in_ready=0 from the next cycle.
- Full hold: while fill_full=1, on the first cycle with out_ready=1 the held frame moves into the output register (out_valid stays 1). fill_full clears and the fill buffer zeroes on that edge.
- Consume without replacement: out_valid clears on out_ready when no completed frame is pending.
- Output stability: out_data and out_cnt are stable while out_valid & !out_ready.
  - out_data and out_cnt are forced to 0 whenever out_valid=0.
- Fill buffer hygiene: the fill buffer zeroes whenever a frame leaves it, so unwritten slots are always 0.
- Simultaneous final accept and out_ready with out_valid=1: the old frame is consumed and the new one loads on the same edge. No bubble, no loss.
- clr: highest priority after reset. On the next edge it forces the same state as reset, including any frame currently in the output register. in_valid is ignored in the clr cycle.
- Pointer: never exceeds NB-1. Illegal parameter combinations (DP % LN != 0) are stopped with $error at elaboration.

Optional Feature:
- SER2PAR_FLUSH_EN defined:
  - in_last port exists.
  - An accepted beat with in_last=1 closes the frame immediately: completion rules as for the final beat, ptr resets to 0.
  - out_cnt = (ptr+1)*LN; remaining words are 0.
  - in_last on the natural final beat is a normal frame.
- Undefined: no in_last port; every frame is exactly DP words and out_cnt is always DP when valid.

Test Plan:
- Reset, then idle: out_valid=0, in_ready=1, out_data=0, out_cnt=0; clr asserted idle keeps this state.
- DP=56, LN=1, out_ready=1, words 1..56 back-to-back -> out_valid rises at the edge accepting word 56; slice k holds k+1; out_cnt=56; out_valid drops next cycle.
- out_ready=0, stream 112 words -> frame 1 held stable; after word 112, in_ready=0; out_ready=1 for one cycle -> frame 2 (57..112) in output, in_ready=1 next cycle.
- DP=8, LN=4, beats {4,3,2,1} then {8,7,6,5} -> out_data words 0..7 = 1..8.
- clr after 20 accepted words, then 56 words starting at 100 -> frame contains 100..155, no pre-clr data.
- SER2PAR_FLUSH_EN, in_last on 10th word -> out_cnt=10, words 0..9 valid, words 10..55 = 0; next frame starts at slot 0.

Source files
------------

// File: rtl/ser2par_stream.sv
// ---------------------------------------------------------------------------
// ser2par_stream
//
// Serial-to-parallel collector for the RepVGG accelerator datapath.
// Beats of LN words are accepted under a valid/ready handshake and packed
// into a DP-word frame. Each completed frame is presented on a valid/ready
// output and held stable until it is consumed. The design has two frame
// stores:
//   - a fill buffer that collects the frame currently being assembled;
//   - an output register that holds the frame offered downstream.
// Because there are two stores, the next frame can be collected while the
// previous frame is still waiting for the consumer.
//
// Parameters:
//   DW - word width in bits
//   DP - words per output frame (must be a multiple of LN)
//   LN - words per input beat (1, 2, 4 or 8)
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear, discards every buffered word
//   in_valid  input beat valid
//   in_ready  input beat accepted when in_valid & in_ready
//   in_data   lane j carries in_data[j*DW +: DW]
//   in_last   early frame close (only with SER2PAR_FLUSH_EN)
//   out_valid parallel frame valid
//   out_ready downstream accepts the frame when out_valid & out_ready
//   out_data  parallel frame, word k at out_data[k*DW +: DW]
//   out_cnt   number of valid words in the frame
//
// Optional build macro:
//   SER2PAR_FLUSH_EN - adds in_last, which closes a frame early. The
//                      unwritten words of that frame read as 0.
// ---------------------------------------------------------------------------
module ser2par_stream #(
    parameter int DW = 32,
    parameter int DP = 56,
    parameter int LN = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW*LN-1:0]        in_data,
`ifdef SER2PAR_FLUSH_EN
    input  logic                    in_last,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DW*DP-1:0]        out_data,
    output logic [$clog2(DP+1)-1:0] out_cnt
);

    localparam int NB = DP / LN;
    localparam int PW = (NB > 1) ? $clog2(NB) : 1;
    localparam int CW = $clog2(DP + 1);
    localparam int FW = DW * DP;
    localparam int BW = DW * LN;

    // Parameter sanity checks, evaluated at elaboration time.
    if (DP % LN != 0) begin : g_bad_dp
        $error("ser2par_stream: DP must be a multiple of LN");
    end
    if (!(LN == 1 || LN == 2 || LN == 4 || LN == 8)) begin : g_bad_ln
        $error("ser2par_stream: LN must be 1, 2, 4 or 8");
    end

    // FILL_HELD means a completed frame is parked in the fill buffer,
    // waiting for the output register to become free.
    typedef enum logic [0:0] {
        FILL_OPEN,
        FILL_HELD
    } fill_state_t;

    fill_state_t   state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [FW-1:0] fill_q, fill_d, fill_wr;
    logic [CW-1:0] held_cnt_q, held_cnt_d;
    logic [FW-1:0] out_q, out_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          out_valid_q, out_valid_d;

    logic          accept;
    logic          last_beat;
    logic          flush_close;
    logic          close;
    logic          out_free;
    logic [CW-1:0] frame_cnt;

`ifdef SER2PAR_FLUSH_EN
    assign flush_close = in_last;
`else
    assign flush_close = 1'b0;
`endif

    // in_ready is decoded from the state flop alone. This keeps out_ready
    // from reaching the upstream handshake combinationally.
    assign in_ready  = (state_q == FILL_OPEN);
    assign accept    = in_valid & in_ready & ~clr;
    assign last_beat = (ptr_q == PW'(NB - 1));
    assign close     = last_beat | flush_close;
    assign out_free  = ~out_valid_q | out_ready;

    // A frame closed early holds (ptr+1)*LN words. A frame closed on its
    // natural final beat is always full.
`ifdef SER2PAR_FLUSH_EN
    assign frame_cnt = last_beat ? CW'(DP) : CW'((int'(ptr_q) + 1) * LN);
`else
    assign frame_cnt = CW'(DP);
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_q;
    assign out_cnt   = out_cnt_q;

    // Merge the incoming beat into the fill buffer image at slot ptr*LN.
    // Comparing ptr against each beat index keeps every slice constant,
    // so each beat position gets a plain write enable.
    always_comb begin
        fill_wr = fill_q;
        for (int b = 0; b < NB; b++) begin
            if (ptr_q == PW'(b)) begin
                fill_wr[b*BW +: BW] = in_data;
            end
        end
    end

    // Next-state logic for the fill state, beat pointer and both frame
    // stores. clr resets everything on the next edge, including a frame
    // already offered downstream. Whenever a frame leaves a store, that
    // store is zeroed, so an idle output reads as 0 and a short frame
    // never carries stale words.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        held_cnt_d  = held_cnt_q;
        out_d       = out_q;
        out_cnt_d   = out_cnt_q;
        out_valid_d = out_valid_q;

        if (clr) begin
            state_d     = FILL_OPEN;
            ptr_d       = '0;
            fill_d      = '0;
            held_cnt_d  = '0;
            out_d       = '0;
            out_cnt_d   = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                FILL_OPEN: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_d = 1'b0;
                        out_d       = '0;
                        out_cnt_d   = '0;
                    end
                    if (accept) begin
                        if (close) begin
                            ptr_d = '0;
                            if (out_free) begin
                                out_d       = fill_wr;
                                out_cnt_d   = frame_cnt;
                                out_valid_d = 1'b1;
                                fill_d      = '0;
                            end else begin
                                state_d    = FILL_HELD;
                                fill_d     = fill_wr;
                                held_cnt_d = frame_cnt;
                            end
                        end else begin
                            ptr_d  = ptr_q + PW'(1);
                            fill_d = fill_wr;
                        end
                    end
                end
                FILL_HELD: begin
                    if (out_ready) begin
                        out_d       = fill_q;
                        out_cnt_d   = held_cnt_q;
                        out_valid_d = 1'b1;
                        fill_d      = '0;
                        held_cnt_d  = '0;
                        state_d     = FILL_OPEN;
                    end
                end
                default: begin
                    state_d = FILL_OPEN;
                end
            endcase
        end
    end

    // State register. The asynchronous reset brings the block to the
    // empty, ready-to-accept state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL_OPEN;
            ptr_q       <= '0;
            fill_q      <= '0;
            held_cnt_q  <= '0;
            out_q       <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            held_cnt_q  <= held_cnt_d;
            out_q       <= out_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
